// File: rtl/issue_hazard_ctrl.sv
// Stall / split-issue controller for the 2-wide pipeline: resolves load-use and
// intra-pair hazards that forwarding cannot cover, and keeps hazard statistics.
module issue_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src1_1_ID_RF,
  input  logic [3:0]  src2_1_ID_RF,
  input  logic [3:0]  src1_2_ID_RF,
  input  logic [3:0]  src2_2_ID_RF,
  input  logic [2:0]  dest_1_ID_RF,
  input  logic [2:0]  dest_2_ID_RF,
  input  logic        wb_1_ID_RF,
  input  logic        wb_2_ID_RF,
  input  logic        valid1_ID_RF,
  input  logic        valid2_ID_RF,
  input  logic [2:0]  dest_1_RF_EX,
  input  logic [2:0]  dest_2_RF_EX,
  input  logic        wb_1_RF_EX,
  input  logic        wb_2_RF_EX,
  input  logic        valid1_RF_EX,
  input  logic        valid2_RF_EX,
  input  logic        load_1_RF_EX,
  input  logic        load_2_RF_EX,
  input  logic        flush,
  input  logic        clear_cnt,
  output logic        stall_IF_ID,
  output logic        stall_ID_RF,
  output logic        bubble_RF_EX,
  output logic        kill1_RF_EX,
  output logic        kill2_RF_EX,
  output logic        in_split,
  output logic [15:0] stall_cycles,
  output logic [15:0] split_count
);

  typedef enum logic {RUN = 1'b0, SPLIT2 = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_lu1;
  logic        w_lu2;
  logic        w_dep;
  logic        w_split_start;
  logic        w_unused;

  function automatic logic op_match(input logic [3:0] src, input logic [2:0] dest,
                                    input logic vld, input logic wb);
    return src[3] && (src[2:0] == dest) && vld && wb;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Slot 2's own destination never creates a hazard at this boundary.
  assign w_unused = ^{dest_2_ID_RF, wb_2_ID_RF};

  // Only load producers in RF/EX count; ALU results are forwarded instead.
  assign w_lu1 = valid1_ID_RF &
    (op_match(src1_1_ID_RF, dest_1_RF_EX, valid1_RF_EX & load_1_RF_EX, wb_1_RF_EX) |
     op_match(src2_1_ID_RF, dest_1_RF_EX, valid1_RF_EX & load_1_RF_EX, wb_1_RF_EX) |
     op_match(src1_1_ID_RF, dest_2_RF_EX, valid2_RF_EX & load_2_RF_EX, wb_2_RF_EX) |
     op_match(src2_1_ID_RF, dest_2_RF_EX, valid2_RF_EX & load_2_RF_EX, wb_2_RF_EX));

  assign w_lu2 = valid2_ID_RF &
    (op_match(src1_2_ID_RF, dest_1_RF_EX, valid1_RF_EX & load_1_RF_EX, wb_1_RF_EX) |
     op_match(src2_2_ID_RF, dest_1_RF_EX, valid1_RF_EX & load_1_RF_EX, wb_1_RF_EX) |
     op_match(src1_2_ID_RF, dest_2_RF_EX, valid2_RF_EX & load_2_RF_EX, wb_2_RF_EX) |
     op_match(src2_2_ID_RF, dest_2_RF_EX, valid2_RF_EX & load_2_RF_EX, wb_2_RF_EX));

  assign w_dep = valid1_ID_RF & valid2_ID_RF & wb_1_ID_RF &
    (op_match(src1_2_ID_RF, dest_1_ID_RF, 1'b1, 1'b1) |
     op_match(src2_2_ID_RF, dest_1_ID_RF, 1'b1, 1'b1));

  always_comb begin
    stall_IF_ID  = 1'b0;
    stall_ID_RF  = 1'b0;
    bubble_RF_EX = 1'b0;
    kill1_RF_EX  = 1'b0;
    kill2_RF_EX  = 1'b0;
    w_next       = r_state;
    if (!rst_n) begin
      w_next = RUN;
    end else if (flush) begin
      w_next = RUN;
    end else if (r_state == RUN) begin
      if (w_lu1 | w_lu2) begin
        stall_IF_ID  = 1'b1;
        stall_ID_RF  = 1'b1;
        bubble_RF_EX = 1'b1;
      end else if (w_dep) begin
        stall_IF_ID = 1'b1;
        stall_ID_RF = 1'b1;
        kill2_RF_EX = 1'b1;
        w_next      = SPLIT2;
      end
    end else begin
      if (w_lu2) begin
        stall_IF_ID  = 1'b1;
        stall_ID_RF  = 1'b1;
        bubble_RF_EX = 1'b1;
      end else begin
        kill1_RF_EX = 1'b1;
        w_next      = RUN;
      end
    end
  end

  assign in_split      = rst_n & (r_state == SPLIT2);
  assign w_split_start = (r_state == RUN) & (w_next == SPLIT2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      stall_cycles <= 16'd0;
      split_count  <= 16'd0;
    end else begin
      r_state <= w_next;
      if (clear_cnt) begin
        stall_cycles <= 16'd0;
        split_count  <= 16'd0;
      end else begin
        if (stall_ID_RF)   stall_cycles <= sat_inc(stall_cycles);
        if (w_split_start) split_count  <= sat_inc(split_count);
      end
    end
  end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed bench for issue_hazard_ctrl: expected outputs queued per step,
// popped and checked mid-cycle.
module tb_issue_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src1_1_ID_RF, src2_1_ID_RF, src1_2_ID_RF, src2_2_ID_RF;
  logic [2:0]  dest_1_ID_RF, dest_2_ID_RF;
  logic        wb_1_ID_RF, wb_2_ID_RF, valid1_ID_RF, valid2_ID_RF;
  logic [2:0]  dest_1_RF_EX, dest_2_RF_EX;
  logic        wb_1_RF_EX, wb_2_RF_EX, valid1_RF_EX, valid2_RF_EX;
  logic        load_1_RF_EX, load_2_RF_EX;
  logic        flush, clear_cnt;
  logic        stall_IF_ID, stall_ID_RF, bubble_RF_EX, kill1_RF_EX, kill2_RF_EX, in_split;
  logic [15:0] stall_cycles, split_count;

  // control vector order: stall_IF_ID, stall_ID_RF, bubble, kill1, kill2, in_split
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b111000;
  localparam logic [5:0] C_LU_S  = 6'b111001;
  localparam logic [5:0] C_SPLIT = 6'b110010;
  localparam logic [5:0] C_K1    = 6'b000101;
  localparam logic [5:0] C_INS   = 6'b000001;

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic [15:0] sc;
    logic [15:0] spc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  issue_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .src1_1_ID_RF(src1_1_ID_RF), .src2_1_ID_RF(src2_1_ID_RF),
    .src1_2_ID_RF(src1_2_ID_RF), .src2_2_ID_RF(src2_2_ID_RF),
    .dest_1_ID_RF(dest_1_ID_RF), .dest_2_ID_RF(dest_2_ID_RF),
    .wb_1_ID_RF(wb_1_ID_RF), .wb_2_ID_RF(wb_2_ID_RF),
    .valid1_ID_RF(valid1_ID_RF), .valid2_ID_RF(valid2_ID_RF),
    .dest_1_RF_EX(dest_1_RF_EX), .dest_2_RF_EX(dest_2_RF_EX),
    .wb_1_RF_EX(wb_1_RF_EX), .wb_2_RF_EX(wb_2_RF_EX),
    .valid1_RF_EX(valid1_RF_EX), .valid2_RF_EX(valid2_RF_EX),
    .load_1_RF_EX(load_1_RF_EX), .load_2_RF_EX(load_2_RF_EX),
    .flush(flush), .clear_cnt(clear_cnt),
    .stall_IF_ID(stall_IF_ID), .stall_ID_RF(stall_ID_RF),
    .bubble_RF_EX(bubble_RF_EX), .kill1_RF_EX(kill1_RF_EX),
    .kill2_RF_EX(kill2_RF_EX), .in_split(in_split),
    .stall_cycles(stall_cycles), .split_count(split_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    src1_1_ID_RF = 4'd0; src2_1_ID_RF = 4'd0; src1_2_ID_RF = 4'd0; src2_2_ID_RF = 4'd0;
    dest_1_ID_RF = 3'd0; dest_2_ID_RF = 3'd0;
    wb_1_ID_RF = 1'b0; wb_2_ID_RF = 1'b0; valid1_ID_RF = 1'b0; valid2_ID_RF = 1'b0;
    dest_1_RF_EX = 3'd0; dest_2_RF_EX = 3'd0;
    wb_1_RF_EX = 1'b0; wb_2_RF_EX = 1'b0; valid1_RF_EX = 1'b0; valid2_RF_EX = 1'b0;
    load_1_RF_EX = 1'b0; load_2_RF_EX = 1'b0;
    flush = 1'b0; clear_cnt = 1'b0;
  endtask

  // RF/EX slot 1 is a load writing r3; ID/RF slot 1 reads r3.
  task automatic set_lu1();
    idle();
    valid1_RF_EX = 1'b1; wb_1_RF_EX = 1'b1; load_1_RF_EX = 1'b1; dest_1_RF_EX = 3'd3;
    valid1_ID_RF = 1'b1; src1_1_ID_RF = 4'b1011;
  endtask

  // Slot 1 writes r5, slot 2 reads r5.
  task automatic set_dep();
    idle();
    valid1_ID_RF = 1'b1; valid2_ID_RF = 1'b1; wb_1_ID_RF = 1'b1; dest_1_ID_RF = 3'd5;
    src2_2_ID_RF = 4'b1101;
  endtask

  // Push expectation, sample on the falling edge, then advance past the next rising edge.
  task automatic chk(input string tag, input logic [5:0] ctl,
                     input logic [15:0] sc, input logic [15:0] spc);
    exp_t e;
    exp_t g;
    logic [5:0] obs;
    e.tag = tag; e.ctl = ctl; e.sc = sc; e.spc = spc;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs = {stall_IF_ID, stall_ID_RF, bubble_RF_EX, kill1_RF_EX, kill2_RF_EX, in_split};
    n_total++;
    assert (obs === g.ctl) n_pass++;
    else $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
    n_total++;
    assert (stall_cycles === g.sc) n_pass++;
    else $error("FAIL %s stall_cycles observed=%0h expected=%0h", g.tag, stall_cycles, g.sc);
    n_total++;
    assert (split_count === g.spc) n_pass++;
    else $error("FAIL %s split_count observed=%0h expected=%0h", g.tag, split_count, g.spc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    set_lu1();
    chk("reset_forces_zero", C_NONE, 16'd0, 16'd0);
    rst_n = 1'b1;
    idle();
    chk("idle", C_NONE, 16'd0, 16'd0);

    set_lu1();
    chk("load_use", C_LU, 16'd0, 16'd0);
    valid1_RF_EX = 1'b0;
    chk("after_bubble", C_NONE, 16'd1, 16'd0);
    valid1_RF_EX = 1'b1; src1_1_ID_RF = 4'b0011;
    chk("unused_operand", C_NONE, 16'd1, 16'd0);
    src1_1_ID_RF = 4'b1011; wb_1_RF_EX = 1'b0;
    chk("producer_no_wb", C_NONE, 16'd1, 16'd0);
    wb_1_RF_EX = 1'b1; load_1_RF_EX = 1'b0;
    chk("non_load_match", C_NONE, 16'd1, 16'd0);
    set_dep(); src2_2_ID_RF = 4'b0101;
    chk("dep_unused_bit", C_NONE, 16'd1, 16'd0);

    set_dep();
    chk("split_c0", C_SPLIT, 16'd1, 16'd0);
    chk("split_c1", C_K1, 16'd2, 16'd1);
    idle();
    chk("split_done", C_NONE, 16'd2, 16'd1);

    set_dep();
    chk("ldpair_c0", C_SPLIT, 16'd2, 16'd1);
    valid1_RF_EX = 1'b1; wb_1_RF_EX = 1'b1; load_1_RF_EX = 1'b1; dest_1_RF_EX = 3'd5;
    chk("ldpair_c1_lu2", C_LU_S, 16'd3, 16'd2);
    valid1_RF_EX = 1'b0;
    chk("ldpair_c2", C_K1, 16'd4, 16'd2);
    idle();
    chk("ldpair_done", C_NONE, 16'd4, 16'd2);

    idle();
    valid2_RF_EX = 1'b1; wb_2_RF_EX = 1'b1; load_2_RF_EX = 1'b1; dest_2_RF_EX = 3'd6;
    valid2_ID_RF = 1'b1; src1_2_ID_RF = 4'b1110;
    chk("lu2_from_slot2", C_LU, 16'd4, 16'd2);
    set_dep();
    valid1_RF_EX = 1'b1; wb_1_RF_EX = 1'b1; load_1_RF_EX = 1'b1; dest_1_RF_EX = 3'd2;
    src1_1_ID_RF = 4'b1010;
    chk("lu_beats_dep", C_LU, 16'd5, 16'd2);
    idle();
    chk("no_split_after_lu", C_NONE, 16'd6, 16'd2);

    set_dep();
    chk("flush_setup", C_SPLIT, 16'd6, 16'd2);
    valid1_RF_EX = 1'b1; wb_1_RF_EX = 1'b1; load_1_RF_EX = 1'b1; dest_1_RF_EX = 3'd5;
    flush = 1'b1;
    chk("flush_in_split", C_INS, 16'd7, 16'd3);
    idle();
    chk("after_flush", C_NONE, 16'd7, 16'd3);

    set_dep();
    chk("rst_setup", C_SPLIT, 16'd7, 16'd3);
    valid1_RF_EX = 1'b1; wb_1_RF_EX = 1'b1; load_1_RF_EX = 1'b1; dest_1_RF_EX = 3'd5;
    chk("rst_setup_lu2", C_LU_S, 16'd8, 16'd4);
    rst_n = 1'b0;
    chk("reset_mid_split", C_NONE, 16'd0, 16'd0);
    rst_n = 1'b1;
    idle();
    chk("after_reset", C_NONE, 16'd0, 16'd0);

    set_lu1();
    repeat (65540) @(posedge clk);
    #1;
    chk("saturated", C_LU, 16'hFFFF, 16'd0);
    clear_cnt = 1'b1;
    chk("clear_pulse", C_LU, 16'hFFFF, 16'd0);
    clear_cnt = 1'b0;
    chk("cleared", C_LU, 16'd0, 16'd0);
    idle();
    chk("count_restart", C_NONE, 16'd1, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
